// File: rtl/legv8_ctrl_pkg.sv
// Shared LEGv8 control definitions: opcode match patterns, FSM state encoding,
// instruction classes and the ALU/sign-extend control values for each class.
package legv8_ctrl_pkg;

  localparam int LEGV8_OPCODE_W = 11;

  // '?' bits are don't-care positions for casez matching
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_ADDI = 11'b1001000100?;
  localparam logic [10:0] OPC_SUBI = 11'b1101000100?;
  localparam logic [10:0] OPC_MOVZ = 11'b110100101??;
  localparam logic [10:0] OPC_B    = 11'b000101?????;
  localparam logic [10:0] OPC_CBZ  = 11'b10110100???;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    ANDR, ORRR, ADDR, SUBR, ADDI, SUBI, MOVZ, B, CBZ, LDUR, STUR, ILL
  } instr_class_e;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  localparam logic [1:0] SIGN_I  = 2'b00;
  localparam logic [1:0] SIGN_D  = 2'b01;
  localparam logic [1:0] SIGN_B  = 2'b10;
  localparam logic [1:0] SIGN_CB = 2'b11;

  typedef struct packed {
    logic       reg2loc;
    logic       alusrc;
    logic [3:0] aluop;
    logic [1:0] signop;
  } alu_ctrl_t;

  // Single-cycle datapath controls per class; don't-care fields are left at 0
  function automatic alu_ctrl_t class_alu_ctrl(input instr_class_e c);
    alu_ctrl_t a;
    a = '0;
    case (c)
      ANDR: a.aluop = ALU_AND;
      ORRR: a.aluop = ALU_ORR;
      ADDR: a.aluop = ALU_ADD;
      SUBR: a.aluop = ALU_SUB;
      ADDI: begin a.alusrc = 1'b1; a.aluop = ALU_ADD;   a.signop = SIGN_I; end
      SUBI: begin a.alusrc = 1'b1; a.aluop = ALU_SUB;   a.signop = SIGN_I; end
      MOVZ: begin a.alusrc = 1'b1; a.aluop = ALU_PASSB; end
      B:    a.signop = SIGN_B;
      CBZ:  begin a.reg2loc = 1'b1; a.aluop = ALU_PASSB; a.signop = SIGN_CB; end
      LDUR: begin a.alusrc = 1'b1; a.aluop = ALU_ADD; a.signop = SIGN_D; end
      STUR: begin
        a.reg2loc = 1'b1;
        a.alusrc  = 1'b1;
        a.aluop   = ALU_ADD;
        a.signop  = SIGN_D;
      end
      default: a = '0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/opcode_classifier.sv
// Combinational LEGv8 opcode to instruction-class decoder, shared with the
// single-cycle control unit.
module opcode_classifier
  import legv8_ctrl_pkg::*;
(
  input  logic [LEGV8_OPCODE_W-1:0] i_opcode,
  output instr_class_e              o_class
);

  always_comb begin
    o_class = ILL;
    casez (i_opcode)
      OPC_AND:  o_class = ANDR;
      OPC_ORR:  o_class = ORRR;
      OPC_ADD:  o_class = ADDR;
      OPC_SUB:  o_class = SUBR;
      OPC_ADDI: o_class = ADDI;
      OPC_SUBI: o_class = SUBI;
      OPC_MOVZ: o_class = MOVZ;
      OPC_B:    o_class = B;
      OPC_CBZ:  o_class = CBZ;
      OPC_LDUR: o_class = LDUR;
      OPC_STUR: o_class = STUR;
      default:  o_class = ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle LEGv8 control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// variable-latency memory handshake, memory timeout fault and illegal-opcode pulse.
module multicycle_control
  import legv8_ctrl_pkg::*;
#(
  parameter int OPCODE_W    = LEGV8_OPCODE_W,
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                i_clk,
  input  logic                i_resetl,
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic                i_zero,
  input  logic                i_mem_ready,
  output logic                o_ir_write,
  output logic                o_pc_write,
  output logic [1:0]          o_pc_src,
  output logic                o_iord,
  output logic                o_reg2loc,
  output logic                o_alusrc,
  output logic                o_mem2reg,
  output logic                o_regwrite,
  output logic                o_memread,
  output logic                o_memwrite,
  output logic [ALUOP_W-1:0]  o_aluop,
  output logic [1:0]          o_signop,
  output logic                o_instr_done,
  output logic                o_illegal,
  output logic                o_fault,
  output logic [2:0]          o_state
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e          r_state;
  state_e          w_next;
  instr_class_e    r_class;
  instr_class_e    w_dec_class;
  logic [CNT_W-1:0] r_cnt;
  logic            r_fault;
  logic            w_expired;
  alu_ctrl_t       w_alu;
  logic            w_ir_write, w_pc_write, w_iord, w_mem2reg, w_regwrite;
  logic            w_memread, w_memwrite, w_instr_done, w_illegal;
  logic [1:0]      w_pc_src;

  opcode_classifier u_classifier (
    .i_opcode (i_opcode),
    .o_class  (w_dec_class)
  );

  always_comb begin
    w_next       = r_state;
    w_alu        = '0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_src     = 2'b00;
    w_iord       = 1'b0;
    w_mem2reg    = 1'b0;
    w_regwrite   = 1'b0;
    w_memread    = 1'b0;
    w_memwrite   = 1'b0;
    w_instr_done = 1'b0;
    w_illegal    = 1'b0;
    // A ready on the final allowed wait cycle still completes the access
    w_expired    = (MEM_TIMEOUT != 0) && (r_cnt == CNT_LAST) && !i_mem_ready;

    case (r_state)
      ST_FETCH: begin
        w_memread = 1'b1;
        if (i_mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = ST_DECODE;
        end else if (w_expired) begin
          w_next = ST_FAULT;
        end
      end
      ST_DECODE: begin
        if (w_dec_class == ILL) begin
          w_illegal = 1'b1;
          w_next    = ST_FETCH;
        end else begin
          w_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_alu = class_alu_ctrl(r_class);
        case (r_class)
          B: begin
            w_pc_write   = 1'b1;
            w_pc_src     = 2'b01;
            w_instr_done = 1'b1;
            w_next       = ST_FETCH;
          end
          CBZ: begin
            w_pc_write   = i_zero;
            w_pc_src     = 2'b01;
            w_instr_done = 1'b1;
            w_next       = ST_FETCH;
          end
          LDUR, STUR: w_next = ST_MEM;
          default:    w_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        w_alu      = class_alu_ctrl(r_class);
        w_iord     = 1'b1;
        w_memread  = (r_class == LDUR);
        w_memwrite = (r_class == STUR);
        if (i_mem_ready) begin
          if (r_class == STUR) begin
            w_instr_done = 1'b1;
            w_next       = ST_FETCH;
          end else begin
            w_next = ST_WB;
          end
        end else if (w_expired) begin
          w_next = ST_FAULT;
        end
      end
      ST_WB: begin
        w_alu        = class_alu_ctrl(r_class);
        w_regwrite   = 1'b1;
        w_instr_done = 1'b1;
        w_mem2reg    = (r_class == LDUR);
        w_next       = ST_FETCH;
      end
      ST_FAULT: w_next = ST_FAULT;
      default:  w_next = ST_FETCH;
    endcase
  end

  // Wait counter restarts on every state change, so entry to FETCH/MEM starts at 0
  always_ff @(posedge i_clk) begin
    if (!i_resetl) begin
      r_state <= ST_FETCH;
      r_class <= ANDR;
      r_cnt   <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE) begin
        r_class <= w_dec_class;
      end
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if ((r_state == ST_FETCH || r_state == ST_MEM) && !i_mem_ready) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_next == ST_FAULT) begin
        r_fault <= 1'b1;
      end
    end
  end

  assign o_ir_write   = i_resetl & w_ir_write;
  assign o_pc_write   = i_resetl & w_pc_write;
  assign o_pc_src     = i_resetl ? w_pc_src : 2'b00;
  assign o_iord       = i_resetl & w_iord;
  assign o_reg2loc    = i_resetl & w_alu.reg2loc;
  assign o_alusrc     = i_resetl & w_alu.alusrc;
  assign o_mem2reg    = i_resetl & w_mem2reg;
  assign o_regwrite   = i_resetl & w_regwrite;
  assign o_memread    = i_resetl & w_memread;
  assign o_memwrite   = i_resetl & w_memwrite;
  assign o_aluop      = i_resetl ? ALUOP_W'(w_alu.aluop) : '0;
  assign o_signop     = i_resetl ? w_alu.signop : 2'b00;
  assign o_instr_done = i_resetl & w_instr_done;
  assign o_illegal    = i_resetl & w_illegal;
  assign o_fault      = i_resetl & r_fault;
  assign o_state      = i_resetl ? r_state : 3'd0;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each stimulus cycle queues its
// hand-computed expected outputs, and a negedge monitor pops and compares them.
module tb_multicycle_control;

  typedef struct packed {
    logic [2:0] st;
    logic       irw;
    logic       pcw;
    logic [1:0] pcs;
    logic       io;
    logic       r2l;
    logic       asrc;
    logic       m2r;
    logic       rw;
    logic       mr;
    logic       mw;
    logic [3:0] alu;
    logic [1:0] sg;
    logic       done;
    logic       ill;
    logic       flt;
  } outVec_t;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUBI = 11'b11010001000;
  localparam logic [10:0] OP_MOVZ = 11'b11010010110;
  localparam logic [10:0] OP_B    = 11'b00010100011;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_BAD  = 11'h000;

  logic        clk;
  logic        resetl;
  logic [10:0] opcode;
  logic        zero;
  logic        memReady;
  logic        irWrite, pcWrite, iord, reg2loc, aluSrc, mem2reg, regWrite;
  logic        memRead, memWrite, instrDone, illegal, fault;
  logic [1:0]  pcSrc, signOp;
  logic [3:0]  aluOp;
  logic [2:0]  state;

  outVec_t expQ[$];
  string   nameQ[$];
  int      total = 0;
  int      bad = 0;
  outVec_t act;

  multicycle_control #(
    .OPCODE_W    (11),
    .ALUOP_W     (4),
    .MEM_TIMEOUT (8)
  ) dut (
    .i_clk        (clk),
    .i_resetl     (resetl),
    .i_opcode     (opcode),
    .i_zero       (zero),
    .i_mem_ready  (memReady),
    .o_ir_write   (irWrite),
    .o_pc_write   (pcWrite),
    .o_pc_src     (pcSrc),
    .o_iord       (iord),
    .o_reg2loc    (reg2loc),
    .o_alusrc     (aluSrc),
    .o_mem2reg    (mem2reg),
    .o_regwrite   (regWrite),
    .o_memread    (memRead),
    .o_memwrite   (memWrite),
    .o_aluop      (aluOp),
    .o_signop     (signOp),
    .o_instr_done (instrDone),
    .o_illegal    (illegal),
    .o_fault      (fault),
    .o_state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign act = {state, irWrite, pcWrite, pcSrc, iord, reg2loc, aluSrc, mem2reg,
                regWrite, memRead, memWrite, aluOp, signOp, instrDone, illegal, fault};

  function automatic outVec_t ev(
    input logic [2:0] st,
    input logic       irw  = 1'b0,
    input logic       pcw  = 1'b0,
    input logic [1:0] pcs  = 2'b00,
    input logic       io   = 1'b0,
    input logic       r2l  = 1'b0,
    input logic       asrc = 1'b0,
    input logic       m2r  = 1'b0,
    input logic       rw   = 1'b0,
    input logic       mr   = 1'b0,
    input logic       mw   = 1'b0,
    input logic [3:0] alu  = 4'b0000,
    input logic [1:0] sg   = 2'b00,
    input logic       done = 1'b0,
    input logic       ill  = 1'b0,
    input logic       flt  = 1'b0
  );
    outVec_t v;
    v = {st, irw, pcw, pcs, io, r2l, asrc, m2r, rw, mr, mw, alu, sg, done, ill, flt};
    return v;
  endfunction

  task automatic checkOutput(input outVec_t expected, input outVec_t actual, input string nm);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=%06h expected=%06h", nm, actual, expected);
    end
  endtask

  // One cycle of stimulus: drive inputs, queue the expected outputs, advance
  task automatic applyStimulus(input logic rl, input logic [10:0] opc, input logic z,
                               input logic rdy, input outVec_t e, input string nm);
    resetl   = rl;
    opcode   = opc;
    zero     = z;
    memReady = rdy;
    expQ.push_back(e);
    nameQ.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic fetchHit(input logic [10:0] opc, input string nm);
    applyStimulus(1'b1, opc, 1'b0, 1'b1, ev(.st(3'd0), .irw(1'b1), .pcw(1'b1), .mr(1'b1)), nm);
  endtask

  task automatic fetchWait(input string nm);
    applyStimulus(1'b1, OP_ADD, 1'b0, 1'b0, ev(.st(3'd0), .mr(1'b1)), nm);
  endtask

  always @(negedge clk) begin
    outVec_t e;
    string   n;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      n = nameQ.pop_front();
      checkOutput(e, act, n);
    end
  end

  initial begin
    resetl   = 1'b0;
    opcode   = 11'h000;
    zero     = 1'b0;
    memReady = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus(1'b0, OP_ADD, 1'b0, 1'b1, ev(.st(3'd0)), "reset0");
    applyStimulus(1'b0, OP_ADD, 1'b0, 1'b1, ev(.st(3'd0)), "reset1");

    fetchHit(OP_ADD, "add_fetch");
    applyStimulus(1'b1, OP_ADD, 1'b0, 1'b1, ev(.st(3'd1)), "add_decode");
    applyStimulus(1'b1, OP_ADD, 1'b0, 1'b1, ev(.st(3'd2), .alu(4'b0010)), "add_exec");
    applyStimulus(1'b1, OP_ADD, 1'b0, 1'b1,
                  ev(.st(3'd4), .alu(4'b0010), .rw(1'b1), .done(1'b1)), "add_wb");

    fetchHit(OP_SUBI, "subi_fetch");
    applyStimulus(1'b1, OP_SUBI, 1'b0, 1'b1, ev(.st(3'd1)), "subi_decode");
    applyStimulus(1'b1, OP_SUBI, 1'b0, 1'b1,
                  ev(.st(3'd2), .asrc(1'b1), .alu(4'b0110)), "subi_exec");
    applyStimulus(1'b1, OP_SUBI, 1'b0, 1'b1,
                  ev(.st(3'd4), .asrc(1'b1), .alu(4'b0110), .rw(1'b1), .done(1'b1)), "subi_wb");

    fetchHit(OP_LDUR, "ldur_fetch");
    applyStimulus(1'b1, OP_LDUR, 1'b0, 1'b1, ev(.st(3'd1)), "ldur_decode");
    applyStimulus(1'b1, OP_LDUR, 1'b0, 1'b1,
                  ev(.st(3'd2), .asrc(1'b1), .alu(4'b0010), .sg(2'b01)), "ldur_exec");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, OP_LDUR, 1'b0, 1'b0,
                    ev(.st(3'd3), .io(1'b1), .asrc(1'b1), .alu(4'b0010), .sg(2'b01), .mr(1'b1)),
                    $sformatf("ldur_memwait%0d", i));
    end
    applyStimulus(1'b1, OP_LDUR, 1'b0, 1'b1,
                  ev(.st(3'd3), .io(1'b1), .asrc(1'b1), .alu(4'b0010), .sg(2'b01), .mr(1'b1)),
                  "ldur_memready");
    applyStimulus(1'b1, OP_LDUR, 1'b0, 1'b1,
                  ev(.st(3'd4), .asrc(1'b1), .alu(4'b0010), .sg(2'b01), .m2r(1'b1),
                     .rw(1'b1), .done(1'b1)), "ldur_wb");

    fetchHit(OP_STUR, "stur_fetch");
    applyStimulus(1'b1, OP_STUR, 1'b0, 1'b1, ev(.st(3'd1)), "stur_decode");
    applyStimulus(1'b1, OP_STUR, 1'b0, 1'b1,
                  ev(.st(3'd2), .r2l(1'b1), .asrc(1'b1), .alu(4'b0010), .sg(2'b01)), "stur_exec");
    applyStimulus(1'b1, OP_STUR, 1'b0, 1'b1,
                  ev(.st(3'd3), .io(1'b1), .r2l(1'b1), .asrc(1'b1), .alu(4'b0010), .sg(2'b01),
                     .mw(1'b1), .done(1'b1)), "stur_mem");

    fetchHit(OP_CBZ, "cbz0_fetch");
    applyStimulus(1'b1, OP_CBZ, 1'b0, 1'b1, ev(.st(3'd1)), "cbz0_decode");
    applyStimulus(1'b1, OP_CBZ, 1'b0, 1'b1,
                  ev(.st(3'd2), .pcs(2'b01), .r2l(1'b1), .alu(4'b0111), .sg(2'b11), .done(1'b1)),
                  "cbz0_exec");
    fetchHit(OP_CBZ, "cbz1_fetch");
    applyStimulus(1'b1, OP_CBZ, 1'b1, 1'b1, ev(.st(3'd1)), "cbz1_decode");
    applyStimulus(1'b1, OP_CBZ, 1'b1, 1'b1,
                  ev(.st(3'd2), .pcw(1'b1), .pcs(2'b01), .r2l(1'b1), .alu(4'b0111), .sg(2'b11),
                     .done(1'b1)), "cbz1_exec");

    fetchHit(OP_B, "b_fetch");
    applyStimulus(1'b1, OP_B, 1'b0, 1'b1, ev(.st(3'd1)), "b_decode");
    applyStimulus(1'b1, OP_B, 1'b0, 1'b1,
                  ev(.st(3'd2), .pcw(1'b1), .pcs(2'b01), .sg(2'b10), .done(1'b1)), "b_exec");

    fetchHit(OP_MOVZ, "movz_fetch");
    applyStimulus(1'b1, OP_MOVZ, 1'b0, 1'b1, ev(.st(3'd1)), "movz_decode");
    applyStimulus(1'b1, OP_MOVZ, 1'b0, 1'b1,
                  ev(.st(3'd2), .asrc(1'b1), .alu(4'b0111)), "movz_exec");
    applyStimulus(1'b1, OP_MOVZ, 1'b0, 1'b1,
                  ev(.st(3'd4), .asrc(1'b1), .alu(4'b0111), .rw(1'b1), .done(1'b1)), "movz_wb");

    fetchHit(OP_BAD, "ill_fetch");
    applyStimulus(1'b1, OP_BAD, 1'b0, 1'b1, ev(.st(3'd1), .ill(1'b1)), "ill_decode");
    fetchHit(OP_ADD, "ill_refetch");
    applyStimulus(1'b1, OP_ADD, 1'b0, 1'b1, ev(.st(3'd1)), "ill_after_decode");
    applyStimulus(1'b1, OP_ADD, 1'b0, 1'b1, ev(.st(3'd2), .alu(4'b0010)), "ill_after_exec");
    applyStimulus(1'b1, OP_ADD, 1'b0, 1'b1,
                  ev(.st(3'd4), .alu(4'b0010), .rw(1'b1), .done(1'b1)), "ill_after_wb");

    for (int i = 0; i < 7; i++) fetchWait($sformatf("late_wait%0d", i));
    fetchHit(OP_ADD, "late_ready_cycle8");
    applyStimulus(1'b1, OP_ADD, 1'b0, 1'b1, ev(.st(3'd1)), "late_no_fault");
    applyStimulus(1'b1, OP_ADD, 1'b0, 1'b1, ev(.st(3'd2), .alu(4'b0010)), "late_exec");
    applyStimulus(1'b1, OP_ADD, 1'b0, 1'b1,
                  ev(.st(3'd4), .alu(4'b0010), .rw(1'b1), .done(1'b1)), "late_wb");

    for (int i = 0; i < 8; i++) fetchWait($sformatf("to_wait%0d", i));
    applyStimulus(1'b1, OP_ADD, 1'b0, 1'b0, ev(.st(3'd7), .flt(1'b1)), "to_fault0");
    applyStimulus(1'b1, OP_ADD, 1'b0, 1'b1, ev(.st(3'd7), .flt(1'b1)), "to_fault_sticky1");
    applyStimulus(1'b1, OP_ADD, 1'b0, 1'b1, ev(.st(3'd7), .flt(1'b1)), "to_fault_sticky2");
    applyStimulus(1'b0, OP_ADD, 1'b0, 1'b1, ev(.st(3'd0)), "to_reset");
    fetchWait("to_release");
    fetchHit(OP_STUR, "stur2_fetch");
    applyStimulus(1'b1, OP_STUR, 1'b0, 1'b1, ev(.st(3'd1)), "stur2_decode");
    applyStimulus(1'b1, OP_STUR, 1'b0, 1'b0,
                  ev(.st(3'd2), .r2l(1'b1), .asrc(1'b1), .alu(4'b0010), .sg(2'b01)), "stur2_exec");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, OP_STUR, 1'b0, 1'b0,
                    ev(.st(3'd3), .io(1'b1), .r2l(1'b1), .asrc(1'b1), .alu(4'b0010), .sg(2'b01),
                       .mw(1'b1)), $sformatf("stur2_stall%0d", i));
    end
    applyStimulus(1'b0, OP_STUR, 1'b0, 1'b1, ev(.st(3'd0)), "stur2_reset");
    fetchWait("stur2_after_reset");
    fetchHit(OP_ADD, "stur2_refetch");
    applyStimulus(1'b1, OP_ADD, 1'b0, 1'b1, ev(.st(3'd1)), "stur2_next_decode");

    repeat (4) begin
      if (expQ.size() != 0) @(negedge clk);
    end
    if (expQ.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: pending=%0d expected=0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
